struct_array_reader: RTL
========================

STRUCT_ARRAY_READER -- requirements
Module: struct_array_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter NUM_ELEM, default 8: number of packed array elements in the record.
REQ-003 Parameter ELEM_W, default 8: width of each array element in bits.
REQ-004 Parameter FILL_W, default 16: width of the trailing filler field; SHALL be a nonzero multiple of ELEM_W.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port in_valid, input, 1: record offered.
REQ-008 Port in_ready, output, 1: record accepted when in_valid && in_ready.
REQ-009 Port in_rec, input, NUM_ELEM*ELEM_W+FILL_W: packed record {a[NUM_ELEM-1:0][ELEM_W-1:0], b[FILL_W-1:0]}, with b in the LSBs and a[i] at bits FILL_W+ELEM_W*i+ELEM_W-1 : FILL_W+ELEM_W*i.
REQ-010 Port in_asc, input, 1: element order select, sampled at acceptance (1 = a[0] first, 0 = a[NUM_ELEM-1] first).
REQ-011 Port out_valid, output, 1: beat available.
REQ-012 Port out_ready, input, 1: beat consumed when out_valid && out_ready.
REQ-013 Port out_data, output, ELEM_W: beat payload.
REQ-014 Port out_index, output, clog2(NUM_ELEM) (minimum 1): array index of the current element beat; 0 on filler beats.
REQ-015 Port out_is_fill, output, 1: current beat carries a slice of b.
REQ-016 Port out_last, output, 1: current beat is the final beat of the record.

Function
REQ-017 The block SHALL implement the states IDLE, ELEM and FILL.
REQ-018 IDLE: in_ready=1 and out_valid=0; on acceptance, in_rec and in_asc SHALL be captured and the state SHALL change to ELEM.
REQ-019 Latency: the first beat SHALL present out_valid=1 in the cycle after acceptance.
REQ-020 ELEM: the block SHALL emit NUM_ELEM beats, one per handshake. The order SHALL be index 0..NUM_ELEM-1 when asc=1 and NUM_ELEM-1..0 when asc=0. out_data SHALL equal the captured a[out_index].
REQ-021 FILL: the block SHALL emit FILL_W/ELEM_W beats of b, most significant slice first, with out_is_fill=1.
REQ-022 Order is beat-level only; the bits within each slice SHALL NOT be reordered.
REQ-023 The state SHALL advance ELEM->FILL on the handshake of the last element beat and FILL->IDLE on the handshake of the last filler beat.
REQ-024 out_last SHALL be 1 only on the final filler beat.
REQ-025 Backpressure: while out_valid && !out_ready, out_data, out_index, out_is_fill and out_last SHALL hold stable and no counter SHALL advance.
REQ-026 Back-to-back: in_ready SHALL also be 1 in the cycle where the final beat handshakes.
- A record accepted in that cycle SHALL go directly to ELEM.
- Its first beat SHALL appear in the next cycle with no idle gap.
REQ-027 In ELEM/FILL, outside the case in REQ-026, in_ready=0; in_valid SHALL be ignored and in_rec changes SHALL NOT affect beats in flight.
REQ-028 Counters SHALL wrap only via reload at acceptance; no beat SHALL be emitted with an index outside 0..NUM_ELEM-1.
REQ-029 All outputs SHALL be driven from registers or the state only; there SHALL be no combinational path from in_* to out_*.

Reset
REQ-030 rst SHALL force IDLE, with out_valid=0, out_data=0, out_index=0, out_is_fill=0 and out_last=0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 rst asserted mid-record SHALL discard the remaining beats; a record offered while rst=1 SHALL NOT be accepted.

Verification
REQ-033 Defaults, in_rec=80'hFC00_4200_0012_3400_FFFC, asc=0, out_ready=1 -> out_data FC,00,42,00,00,12,34,00,FF,FC; out_index 7..0 then 0,0; out_last only on the 10th beat.
REQ-034 Same record, asc=1 -> out_data 00,34,12,00,00,42,00,FC,FF,FC; out_index 0..7.
REQ-035 Hold out_ready=0 for 3 cycles on beat 3 -> beat 3 is held stable, no beat is lost or duplicated, and the sequence matches REQ-033.
REQ-036 Two records offered back-to-back with in_valid held -> the second is accepted on the first record's last handshake; 20 beats arrive in 20 consecutive cycles.
REQ-037 Assert rst for 1 cycle after beat 4 -> out_valid=0 the next cycle, in_ready=1, and a new record restarts from its first beat.
REQ-038 Toggle in_rec and in_valid during ELEM -> the emitted beats match the originally captured record.

Source files
------------

// File: rtl/struct_array_reader.sv
// Streams a packed record as ELEM_W beats: the array elements in the selected order, then the
// trailing filler field most significant slice first. Outputs come only from registered state.
module struct_array_reader #(
    parameter int unsigned NUM_ELEM = 8,
    parameter int unsigned ELEM_W   = 8,
    parameter int unsigned FILL_W   = 16,
    localparam int unsigned REC_W   = NUM_ELEM * ELEM_W + FILL_W,
    localparam int unsigned IDX_W   = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REC_W-1:0]  in_rec,
    input  logic              in_asc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_is_fill,
    output logic              out_last
);

    localparam int unsigned NUM_FILL = FILL_W / ELEM_W;
    localparam int unsigned FCNT_W   = (NUM_FILL > 1) ? $clog2(NUM_FILL) : 1;
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_ELEM - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(NUM_FILL - 1);

    typedef enum logic [1:0] {StIdle, StElem, StFill} state_e;

    state_e state_q, state_d;

    logic [NUM_ELEM*ELEM_W-1:0] elem_q;
    logic [FILL_W-1:0]          fill_q;
    logic                       asc_q;
    logic [IDX_W-1:0]           idx_q;
    logic [FCNT_W-1:0]          fcnt_q;

    logic              fire_in;
    logic              fire_out;
    logic              last_elem;
    logic              last_fill;
    logic [ELEM_W-1:0] elem_data;

    assign fire_in   = in_valid && in_ready;
    assign fire_out  = out_valid && out_ready;
    assign last_elem = asc_q ? (idx_q == IDX_MAX) : (idx_q == '0);
    assign last_fill = (fcnt_q == FCNT_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (fire_in) state_d = StElem;
            StElem: if (fire_out && last_elem) state_d = StFill;
            StFill: begin
                if (fire_out && last_fill) begin
                    // A record accepted on the final handshake starts with no idle gap.
                    state_d = fire_in ? StElem : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Capture on acceptance; otherwise counters move only on an output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q <= '0;
            fill_q <= '0;
            asc_q  <= 1'b0;
            idx_q  <= '0;
            fcnt_q <= '0;
        end else if (fire_in) begin
            elem_q <= in_rec[REC_W-1:FILL_W];
            fill_q <= in_rec[FILL_W-1:0];
            asc_q  <= in_asc;
            idx_q  <= in_asc ? '0 : IDX_MAX;
            fcnt_q <= '0;
        end else if (fire_out) begin
            if (state_q == StElem && !last_elem) begin
                idx_q <= asc_q ? idx_q + 1'b1 : idx_q - 1'b1;
            end
            if (state_q == StFill && !last_fill) begin
                fcnt_q <= fcnt_q + 1'b1;
                fill_q <= fill_q << ELEM_W;
            end
        end
    end

    always_comb begin
        elem_data = '0;
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            if (idx_q == IDX_W'(i)) elem_data = elem_q[ELEM_W*i +: ELEM_W];
        end
    end

    // Output logic
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_index   = '0;
        out_is_fill = 1'b0;
        out_last    = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StElem: begin
                out_valid = 1'b1;
                out_data  = elem_data;
                out_index = idx_q;
            end
            StFill: begin
                in_ready    = last_fill && out_ready;
                out_valid   = 1'b1;
                out_data    = fill_q[FILL_W-1 -: ELEM_W];
                out_is_fill = 1'b1;
                out_last    = last_fill;
            end
            default: ;
        endcase
    end

endmodule
